mem_arbiter: RTL and testbench

Shares the single physical memory port (the path behind `npc_pmem_read`/`npc_pmem_write`) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the npc core. It accepts one request at a time over valid/ready handshakes and forwards it to memory. It routes the memory response back to the requester that issued it. A watchdog counter converts a hung memory into an error response.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single physical memory port between the instruction-fetch
//   unit (IFU) and the load/store unit (LSU). One transaction is outstanding
//   at a time: IDLE arbitrates and latches a request, ISSUE presents it
//   downstream until accepted, and WAIT routes the response back to the
//   owner. A watchdog turns a hung memory into an error response.
//
// Parameters
//   AW  - address width
//   DW  - data width (write mask is DW/8 bits)
//   TMO - WAIT cycles without response before the watchdog fires (1..255)
//
// Ports
//   clk, reset                         - clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr      - IFU read request
//   ifu_rsp_valid, ifu_rdata, ifu_rsp_err
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
//   lsu_rsp_valid, lsu_rdata, lsu_rsp_err  (writes are acked here too)
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask
//   mem_rsp_valid, mem_rdata           - downstream response
//   busy                               - FSM not in IDLE
//
// Configuration
//   MEM_ARB_RR_EN - when defined, conflicts are resolved round-robin using a
//                   one-bit "last granted" pointer; otherwise the LSU always
//                   wins a conflict.

module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0]    TMO_CNT  = 8'(TMO);
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

  state_t              state;
  logic [7:0]          wd_cnt;
  logic [AW-1:0]       addr_q;
  logic                wen_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wmask_q;
  logic                owner_lsu;
  logic                grant_ifu;
  logic                grant_lsu;
  logic                rsp_fire;
  logic [DW-1:0]       rsp_data;

`ifdef MEM_ARB_RR_EN
  // 1 = LSU was granted last; resets to "IFU last" so LSU wins the first conflict
  logic                last_lsu;
`endif

  // Winner selection among the valid requesters
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
      grant_lsu = ~last_lsu;
      grant_ifu = last_lsu;
`else
      grant_lsu = 1'b1;
`endif
    end else begin
      grant_ifu = ifu_req_valid;
      grant_lsu = lsu_req_valid;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held
  assign ifu_req_ready = reset && (state == IDLE) && grant_ifu;
  assign lsu_req_ready = reset && (state == IDLE) && grant_lsu;

  assign mem_req_valid = (state == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state != IDLE);

  // A real response beats a simultaneous watchdog expiry
  assign rsp_fire = (state == WAIT) && (mem_rsp_valid || (wd_cnt == TMO_CNT));
  assign rsp_data = mem_rsp_valid ? mem_rdata : ERR_DATA;

  assign ifu_rsp_valid = rsp_fire && !owner_lsu;
  assign ifu_rdata     = ifu_rsp_valid ? rsp_data : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && !mem_rsp_valid;

  assign lsu_rsp_valid = rsp_fire && owner_lsu;
  assign lsu_rdata     = lsu_rsp_valid ? rsp_data : '0;
  assign lsu_rsp_err   = lsu_rsp_valid && !mem_rsp_valid;

  // Transaction FSM, latched request fields, watchdog and arbitration pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      owner_lsu <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_lsu  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_lsu) begin
            addr_q    <= lsu_addr;
            wen_q     <= lsu_wen;
            wdata_q   <= lsu_wdata;
            wmask_q   <= lsu_wmask;
            owner_lsu <= 1'b1;
            state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_lsu  <= 1'b1;
`endif
          end else if (grant_ifu) begin
            addr_q    <= ifu_addr;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            owner_lsu <= 1'b0;
            state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_lsu  <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            wd_cnt <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_fire) begin
            state <= IDLE;
          end else if (wd_cnt != TMO_CNT) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (AW=DW=32, TMO=4). Directed steps
//   from the feature list are followed by randomized transactions. A small
//   transaction-level model predicts the winner of each arbitration, the
//   downstream fields, and which WAIT cycle produces the response or the
//   watchdog error. Define MEM_ARB_RR_EN for both bench and DUT to exercise
//   round-robin arbitration.

module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Model state: 1 when the LSU received the most recent grant
  bit last_lsu = 1'b0;

  mem_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL time_limit: simulation still running, required finished");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag,
                             input bit e_iready, input bit e_lready,
                             input bit e_mvalid, input bit e_busy,
                             input bit e_irv, input logic [31:0] e_ird, input bit e_ierr,
                             input bit e_lrv, input logic [31:0] e_lrd, input bit e_lerr);
    check_bit ({tag, ".ifu_req_ready"}, ifu_req_ready, e_iready);
    check_bit ({tag, ".lsu_req_ready"}, lsu_req_ready, e_lready);
    check_bit ({tag, ".mem_req_valid"}, mem_req_valid, e_mvalid);
    check_bit ({tag, ".busy"},          busy,          e_busy);
    check_bit ({tag, ".ifu_rsp_valid"}, ifu_rsp_valid, e_irv);
    check_word({tag, ".ifu_rdata"},     ifu_rdata,     e_ird);
    check_bit ({tag, ".ifu_rsp_err"},   ifu_rsp_err,   e_ierr);
    check_bit ({tag, ".lsu_rsp_valid"}, lsu_rsp_valid, e_lrv);
    check_word({tag, ".lsu_rdata"},     lsu_rdata,     e_lrd);
    check_bit ({tag, ".lsu_rsp_err"},   lsu_rsp_err,   e_lerr);
  endtask

  // Who wins when the given requesters are valid in IDLE
  function automatic bit model_lsu_wins(input bit iv, input bit lv);
    if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
      return !last_lsu;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  // Reset pulse from IDLE; every output must read zero while held
  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset         = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFE0001;
    #1;
    check_cycle(tag, 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
    check_word({tag, ".mem_addr"},  mem_addr,          32'd0);
    check_bit ({tag, ".mem_wen"},   mem_wen,           1'b0);
    check_word({tag, ".mem_wdata"}, mem_wdata,         32'd0);
    check_word({tag, ".mem_wmask"}, 32'(mem_wmask),    32'd0);
    @(negedge clk);
    reset         = 1'b1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    last_lsu      = 1'b0;
  endtask

  // One complete transaction. rsp_dly is the WAIT cycle index on which memory
  // answers; anything outside 0..TMO means memory never answers.
  task automatic apply_stimulus(input string tag, input bit iv, input bit lv,
                                input logic [31:0] iaddr, input logic [31:0] laddr,
                                input bit lwen, input logic [31:0] lwdata, input logic [3:0] lwmask,
                                input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    bit          lsu_owner;
    bit          done;
    bit          exp_err;
    logic [31:0] exp_rd;
    lsu_owner = model_lsu_wins(iv, lv);
    exp_err   = 1'b0;
    exp_rd    = 32'd0;

    @(negedge clk);
    ifu_req_valid = iv;
    ifu_addr      = iaddr;
    lsu_req_valid = lv;
    lsu_addr      = laddr;
    lsu_wen       = lwen;
    lsu_wdata     = lwdata;
    lsu_wmask     = lwmask;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rdata     = $urandom;
    #1;
    check_cycle({tag, ".accept"}, !lsu_owner, lsu_owner, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
    last_lsu = lsu_owner;

    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      mem_req_ready = (k == rdy_dly);
      mem_rsp_valid = 1'($urandom);
      mem_rdata     = $urandom;
      #1;
      check_cycle({tag, ".issue"}, 0, 0, 1, 1, 0, 32'd0, 0, 0, 32'd0, 0);
      check_word({tag, ".mem_addr"},  mem_addr,       lsu_owner ? laddr : iaddr);
      check_bit ({tag, ".mem_wen"},   mem_wen,        lsu_owner ? lwen : 1'b0);
      check_word({tag, ".mem_wmask"}, 32'(mem_wmask), lsu_owner ? 32'(lwmask) : 32'd0);
      if (lsu_owner) check_word({tag, ".mem_wdata"}, mem_wdata, lwdata);
    end

    done = 1'b0;
    for (int w = 0; w <= TMO && !done; w++) begin
      @(negedge clk);
      mem_req_ready = 1'($urandom);
      if (w == rsp_dly) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        exp_rd        = rdata;
        exp_err       = 1'b0;
        done          = 1'b1;
      end else if (w == TMO) begin
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        exp_rd        = 32'hDEADBEEF;
        exp_err       = 1'b1;
        done          = 1'b1;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
      end
      #1;
      if (done)
        check_cycle({tag, ".resp"}, 0, 0, 0, 1,
                    !lsu_owner, lsu_owner ? 32'd0 : exp_rd, !lsu_owner && exp_err,
                    lsu_owner, lsu_owner ? exp_rd : 32'd0, lsu_owner && exp_err);
      else
        check_cycle({tag, ".wait"}, 0, 0, 0, 1, 0, 32'd0, 0, 0, 32'd0, 0);
    end
  endtask

  initial begin
    int          rdy;
    int          rsp;
    bit          iv;
    bit          lv;

    reset         = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h80000000;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h80001000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hFFFFFFFF;
    lsu_wmask     = 4'hF;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h11111111;

    // Reset state with every input active
    repeat (2) @(negedge clk);
    #1;
    check_cycle("reset", 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
    check_word("reset.mem_addr",  mem_addr,       32'd0);
    check_bit ("reset.mem_wen",   mem_wen,        1'b0);
    check_word("reset.mem_wdata", mem_wdata,      32'd0);
    check_word("reset.mem_wmask", 32'(mem_wmask), 32'd0);
    @(negedge clk);
    reset         = 1'b1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;

    // Zero-wait IFU read
    apply_stimulus("ifu_read", 1, 0, 32'h80000000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h00000413);
    // LSU partial write, acked through lsu_rsp_valid
    apply_stimulus("lsu_write", 0, 1, 32'h0, 32'h80001000, 1, 32'h12345678, 4'b0011, 0, 1, 32'h0);
    // Downstream stalls for 5 cycles
    apply_stimulus("stall", 0, 1, 32'h0, 32'h80002004, 0, 32'hA5A5A5A5, 4'b1111, 5, 2, 32'h0BADF00D);

    // Four back-to-back conflicts from a fresh reset
    apply_reset("rst_arb");
    for (int n = 0; n < 4; n++)
      apply_stimulus($sformatf("conflict%0d", n), 1, 1, 32'h80000100 + 32'(n * 4),
                     32'h80003000 + 32'(n * 4), 0, 32'h0, 4'hF, 0, 0, 32'h1000 + 32'(n));

    // Memory never answers, then answers exactly as the watchdog expires
    apply_stimulus("timeout_ifu", 1, 0, 32'h80000040, 32'h0, 0, 32'h0, 4'h0, 0, -1, 32'h0);
    apply_stimulus("timeout_lsu", 0, 1, 32'h0, 32'h80004000, 1, 32'h77, 4'h1, 1, 99, 32'h0);
    apply_stimulus("tie", 0, 1, 32'h0, 32'h80004004, 0, 32'h0, 4'hF, 0, TMO, 32'h5EEDF00D);

    // Reset asserted while waiting for memory
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h80000080;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_cycle("rst_wait.pre", 0, 0, 0, 1, 0, 32'd0, 0, 0, 32'd0, 0);
    @(negedge clk);
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h99999999;
    ifu_req_valid = 1'b1;
    #1;
    check_cycle("rst_wait.held", 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
    check_word("rst_wait.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset         = 1'b1;
    ifu_req_valid = 1'b0;
    #1;
    check_cycle("rst_wait.after", 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);
    last_lsu = 1'b0;
    apply_stimulus("rst_wait.fresh", 1, 0, 32'h800000C0, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h00100073);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      iv  = 1'($urandom);
      lv  = 1'($urandom);
      if (!iv && !lv) lv = 1'b1;
      rdy = int'($urandom_range(0, 3));
      rsp = int'($urandom_range(0, TMO + 2));
      apply_stimulus($sformatf("rand%0d", n), iv, lv, $urandom, $urandom, 1'($urandom),
                     $urandom, 4'($urandom), rdy, rsp, $urandom);
    end

    @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check_cycle("final_idle", 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
